vc_output_unit_p: RTL and testbench
===================================

// Module: vc_output_unit_p
// PURPOSE
//  Parametrised output unit for the mesh router, one instance per output port.
//  Holds one flit FIFO per virtual channel and tracks downstream buffer space with one credit counter per VC.
//  Keeps a per-VC packet lock and sends at most one flit per cycle to the link, choosing among VCs round-robin.
//  Sits between the crossbar (input side) and the neighbour/local link (output side).
//  Reports per-VC ready/lock status back to every input unit.
// PARAMETERS
//  DATA_WIDTH  64  flit width; bits [DATA_WIDTH-1:DATA_WIDTH-2] = flit type
//  NUM_VC      4   number of virtual channels
//  VCH_BITS    2   width of VC index, = clog2(NUM_VC)
//  FIFO_DEPTH  4   flits per VC FIFO; power of 2, >= 2
//  CREDITS     4   downstream buffer depth per VC (credit counter reset value)
// PORTS
//  clk         in   1           clock
//  reset       in   1           async, active-high
//  idata       in   DATA_WIDTH  flit from crossbar
//  ivalid      in   1           idata/ivch valid this cycle
//  ivch        in   VCH_BITS    target VC of idata
//  iack        in   NUM_VC      credit return; 1-cycle pulse per freed downstream slot
//  ordy        out  NUM_VC      VC FIFO not full
//  olck        out  NUM_VC      VC owned by a packet in flight
//  odata       out  DATA_WIDTH  flit to link (registered)
//  ovalid      out  1           odata valid (registered)
//  ovch        out  VCH_BITS    VC of odata (registered)
//  err_ovf     out  1           sticky: write dropped
// BEHAVIOUR
//  Flit type encoding:
//  - 00 single (head+tail), 01 head, 10 body, 11 tail.
//  Reset (async, any time, including mid-packet):
//  - all FIFOs empty; credits = CREDITS; olck = 0; rr_ptr = 0.
//  - odata/ovalid/ovch = 0; err_ovf = 0; ordy = all 1s one delta after reset.
//  - Flits held at reset are discarded.
//  Write side:
//  - ivalid=1 and count[ivch] < FIFO_DEPTH: flit is written at the clock edge.
//  - Write to a full VC, or ivch >= NUM_VC: flit is dropped, FIFO state unchanged, err_ovf set.
//  - err_ovf clears only on reset.
//  - ordy[v] = (count[v] < FIFO_DEPTH), decoded from registers with no combinational path from ivalid.
//  - Write pointers and read pointers wrap modulo FIFO_DEPTH.
//  Lock:
//  - olck[v] sets at the edge that writes a head (01) into v.
//  - olck[v] clears at the edge that sends a tail (11) from v.
//  - Single (00) flits do not change olck.
//  - Head write and tail send on the same VC in the same cycle: olck[v] = 1 (set wins).
//  Eligibility and arbitration:
//  - VC v is eligible when FIFO v is non-empty and credit[v] > 0.
//  - Round-robin scan starts at rr_ptr; the first eligible VC is granted.
//  - After a grant to v, rr_ptr <= (v+1) mod NUM_VC.
//  - With no grant, rr_ptr is held.
//  Send:
//  - Granted head flit registered into odata, ovch <= v, ovalid <= 1; FIFO pops; credit[v] decrements.
//  - With no grant: ovalid <= 0; odata/ovch hold.
//  Latency:
//  - Flit sampled at edge N (empty, credited VC, no competition) drives ovalid=1 in the cycle after edge N+1, i.e. 2 cycles.
//  - Throughput is 1 flit/cycle per port.
//  Simultaneous events:
//  - Write and pop on the same VC: count unchanged; full FIFO accepts the write (pop frees the slot first).
//  - Send and iack[v] on the same VC: credit unchanged.
//  - iack[v] with credit[v] == CREDITS: ignored (saturate), no error.
//  - Credit counter width is clog2(CREDITS+1).
//  - credit[v] == 0: VC stalls, FIFO holds, ordy[v] falls when the FIFO fills.
// TESTING
//  1. Reset with traffic mid-packet -> ovalid=0, olck=0, ordy=4'b1111, err_ovf=0; credits restored to 4.
//  2. Single head flit on VC2 at edge 0 -> ovalid=1, ovch=2 after 2 cycles; olck[2]=1 from edge 0.
//     Tail on VC2 sent -> olck[2]=0.
//  3. VC0..VC3 each loaded with 2 flits, all credited -> ovch order 0,1,2,3,0,1,2,3 with no idle cycles.
//  4. VC1 with CREDITS=4, no iack, 6 flits -> exactly 4 sent, then stall; ordy[1] still 1 (2/4 in FIFO).
//     One iack[1] pulse -> exactly 1 more flit sent.
//  5. Fill VC3 to 4 flits with credit 0 -> ordy[3]=0.
//     Extra write -> dropped, err_ovf=1.
//     Write+pop same cycle with credit restored -> accepted, count stays 4.
//  6. iack[0] pulses while credit[0]=4 -> credit stays 4.
//     Send and iack on VC0 in the same cycle -> credit unchanged.

Source files
------------

// File: rtl/vc_output_unit_p.sv
// rtl/vc_output_unit_p.sv - per-port output unit: per-VC flit FIFOs, credits, packet locks, round-robin link arbiter
//
// Purpose: buffers flits from the crossbar in one FIFO per virtual channel,
// tracks downstream buffer space with one credit counter per VC, keeps a
// per-VC packet lock, and sends at most one flit per cycle to the link.
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   idata/ivalid/ivch flit from crossbar, its valid and target VC
//   iack[NUM_VC]      credit return pulses from downstream
//   ordy[NUM_VC]      VC FIFO not full (registered decode)
//   olck[NUM_VC]      VC owned by a packet in flight
//   odata/ovalid/ovch registered flit to link, valid and VC
//   err_ovf           sticky: a write was dropped
module vc_output_unit_p #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_VC     = 4,
  parameter int VCH_BITS   = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int CREDITS    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] idata,
  input  logic                  ivalid,
  input  logic [VCH_BITS-1:0]   ivch,
  input  logic [NUM_VC-1:0]     iack,
  output logic [NUM_VC-1:0]     ordy,
  output logic [NUM_VC-1:0]     olck,
  output logic [DATA_WIDTH-1:0] odata,
  output logic                  ovalid,
  output logic [VCH_BITS-1:0]   ovch,
  output logic                  err_ovf
);

  localparam int PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNTW = $clog2(FIFO_DEPTH + 1);
  localparam int CW   = $clog2(CREDITS + 1);
  localparam logic [CNTW-1:0]     DEPTH_C = CNTW'(FIFO_DEPTH);
  localparam logic [CW-1:0]       CRED_C  = CW'(CREDITS);
  localparam logic [VCH_BITS:0]   NVC_C   = (VCH_BITS + 1)'(NUM_VC);
  localparam logic [1:0]          T_HEAD  = 2'b01;
  localparam logic [1:0]          T_TAIL  = 2'b11;

  logic [DATA_WIDTH-1:0] r_mem    [NUM_VC][FIFO_DEPTH];
  logic [PW-1:0]         r_wptr   [NUM_VC];
  logic [PW-1:0]         r_rptr   [NUM_VC];
  logic [CNTW-1:0]       r_count  [NUM_VC];
  logic [CW-1:0]         r_credit [NUM_VC];
  logic [NUM_VC-1:0]     r_lck;
  logic [VCH_BITS-1:0]   r_rr;
  logic [DATA_WIDTH-1:0] r_odata;
  logic                  r_ovalid;
  logic [VCH_BITS-1:0]   r_ovch;
  logic                  r_err;

  logic [NUM_VC-1:0]     w_elig;
  logic                  w_gnt;
  logic [VCH_BITS-1:0]   w_gnt_vc;
  logic [VCH_BITS-1:0]   w_cand;
  logic [DATA_WIDTH-1:0] w_gnt_data;
  logic                  w_vc_ok;
  logic                  w_wr;
  logic                  w_drop;
  logic                  w_in_head;
  logic                  w_out_tail;
  logic [NUM_VC-1:0]     w_wr_vec;
  logic [NUM_VC-1:0]     w_pop_vec;

  always_comb begin
    for (int v = 0; v < NUM_VC; v++) begin
      w_elig[v] = (r_count[v] != '0) && (r_credit[v] != '0);
      ordy[v]   = (r_count[v] != DEPTH_C);
    end
  end

  // Round-robin scan starting at r_rr; first eligible VC wins.
  always_comb begin
    w_gnt    = 1'b0;
    w_gnt_vc = '0;
    w_cand   = '0;
    for (int i = 0; i < NUM_VC; i++) begin
      w_cand = VCH_BITS'((int'(r_rr) + i) % NUM_VC);
      if (!w_gnt && w_elig[w_cand]) begin
        w_gnt    = 1'b1;
        w_gnt_vc = w_cand;
      end
    end
  end

  assign w_gnt_data = r_mem[w_gnt_vc][r_rptr[w_gnt_vc]];
  assign w_out_tail = (w_gnt_data[DATA_WIDTH-1:DATA_WIDTH-2] == T_TAIL);
  assign w_in_head  = (idata[DATA_WIDTH-1:DATA_WIDTH-2] == T_HEAD);
  assign w_vc_ok    = ({1'b0, ivch} < NVC_C);

  // A full FIFO still accepts a write when the same VC pops this cycle.
  assign w_wr   = ivalid && w_vc_ok &&
                  ((r_count[ivch] != DEPTH_C) || (w_gnt && (w_gnt_vc == ivch)));
  assign w_drop = ivalid && !w_wr;

  always_comb begin
    for (int v = 0; v < NUM_VC; v++) begin
      w_wr_vec[v]  = w_wr && (ivch == VCH_BITS'(v));
      w_pop_vec[v] = w_gnt && (w_gnt_vc == VCH_BITS'(v));
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[ivch][r_wptr[ivch]] <= idata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int v = 0; v < NUM_VC; v++) begin
        r_wptr[v]   <= '0;
        r_rptr[v]   <= '0;
        r_count[v]  <= '0;
        r_credit[v] <= CRED_C;
      end
      r_lck    <= '0;
      r_rr     <= '0;
      r_odata  <= '0;
      r_ovalid <= 1'b0;
      r_ovch   <= '0;
      r_err    <= 1'b0;
    end else begin
      for (int v = 0; v < NUM_VC; v++) begin
        if (w_wr_vec[v])  r_wptr[v] <= r_wptr[v] + PW'(1);
        if (w_pop_vec[v]) r_rptr[v] <= r_rptr[v] + PW'(1);
        if (w_wr_vec[v] && !w_pop_vec[v])      r_count[v] <= r_count[v] + CNTW'(1);
        else if (!w_wr_vec[v] && w_pop_vec[v]) r_count[v] <= r_count[v] - CNTW'(1);
        // Send and credit return together cancel; returns beyond CREDITS saturate.
        if (w_pop_vec[v] && !iack[v])
          r_credit[v] <= r_credit[v] - CW'(1);
        else if (iack[v] && !w_pop_vec[v] && (r_credit[v] != CRED_C))
          r_credit[v] <= r_credit[v] + CW'(1);
        // Head write has priority over tail send on the same VC.
        if (w_wr_vec[v] && w_in_head)        r_lck[v] <= 1'b1;
        else if (w_pop_vec[v] && w_out_tail) r_lck[v] <= 1'b0;
      end
      if (w_gnt) begin
        r_odata  <= w_gnt_data;
        r_ovch   <= w_gnt_vc;
        r_ovalid <= 1'b1;
        r_rr     <= VCH_BITS'((int'(w_gnt_vc) + 1) % NUM_VC);
      end else begin
        r_ovalid <= 1'b0;
      end
      if (w_drop) r_err <= 1'b1;
    end
  end

  assign olck    = r_lck;
  assign odata   = r_odata;
  assign ovalid  = r_ovalid;
  assign ovch    = r_ovch;
  assign err_ovf = r_err;

endmodule

// File: tb/tb_vc_output_unit_p.sv
// tb/tb_vc_output_unit_p.sv - scoreboard bench for vc_output_unit_p
module tb_vc_output_unit_p;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] idata = '0;
  logic        ivalid = 1'b0;
  logic [1:0]  ivch = '0;
  logic [3:0]  iack = '0;
  logic [3:0]  ordy;
  logic [3:0]  olck;
  logic [63:0] odata;
  logic        ovalid;
  logic [1:0]  ovch;
  logic        err_ovf;

  vc_output_unit_p #(
    .DATA_WIDTH(64), .NUM_VC(4), .VCH_BITS(2), .FIFO_DEPTH(4), .CREDITS(4)
  ) dut (
    .clk(clk), .reset(reset), .idata(idata), .ivalid(ivalid), .ivch(ivch),
    .iack(iack), .ordy(ordy), .olck(olck), .odata(odata), .ovalid(ovalid),
    .ovch(ovch), .err_ovf(err_ovf)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int n_sent = 0;
  int cyc = 0;
  int pl = 0;
  int base = 0;
  logic [63:0] q0[$], q1[$], q2[$], q3[$];
  int log_vc[$];
  int log_cyc[$];
  logic [63:0] last_d, d5, d6, m_exp;
  bit m_have;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int sb_total();
    return q0.size() + q1.size() + q2.size() + q3.size();
  endfunction

  task automatic sb_push(input int v, input logic [63:0] d);
    case (v)
      0: q0.push_back(d);
      1: q1.push_back(d);
      2: q2.push_back(d);
      default: q3.push_back(d);
    endcase
  endtask

  task automatic sb_clear();
    q0.delete(); q1.delete(); q2.delete(); q3.delete();
  endtask

  task automatic put(input int v, input logic [1:0] typ, input bit expect_out);
    pl++;
    last_d = {typ, 62'(pl)};
    idata  = last_d;
    ivch   = 2'(v);
    ivalid = 1'b1;
    if (expect_out) sb_push(v, last_d);
    @(negedge clk);
    ivalid = 1'b0;
  endtask

  task automatic ack(input logic [3:0] m);
    iack = m;
    @(negedge clk);
    iack = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain(input string tag);
    int i;
    i = 0;
    while (sb_total() != 0 && i < 200) begin
      @(negedge clk);
      i++;
    end
    chk(tag, sb_total(), 0);
    idle(4);
  endtask

  always @(posedge clk) cyc++;

  // Link monitor: every sent flit must match the head of its VC's expected queue.
  always @(negedge clk) begin
    if (!reset && ovalid) begin
      n_sent++;
      log_vc.push_back(int'(ovch));
      log_cyc.push_back(cyc);
      m_have = 1'b0;
      case (ovch)
        2'd0: if (q0.size() != 0) begin m_exp = q0.pop_front(); m_have = 1'b1; end
        2'd1: if (q1.size() != 0) begin m_exp = q1.pop_front(); m_have = 1'b1; end
        2'd2: if (q2.size() != 0) begin m_exp = q2.pop_front(); m_have = 1'b1; end
        default: if (q3.size() != 0) begin m_exp = q3.pop_front(); m_have = 1'b1; end
      endcase
      if (m_have) chk("send_data", odata, m_exp);
      else        chk("unexp_send", {63'd0, ovalid}, 64'd0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    idle(2);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ovalid", ovalid, 0);
    chk("rst_olck", olck, 4'h0);
    chk("rst_ordy", ordy, 4'hf);
    chk("rst_err", err_ovf, 0);
    chk("rst_odata", odata, 0);
    chk("rst_ovch", ovch, 0);

    // Head on VC2: lock from write edge, 2-cycle latency; tail send clears lock
    put(2, 2'b01, 1'b1);
    chk("t2_lck_set", olck[2], 1);
    chk("t2_not_yet", ovalid, 0);
    @(negedge clk);
    chk("t2_valid", ovalid, 1);
    chk("t2_vch", ovch, 2);
    put(2, 2'b11, 1'b1);
    chk("t2_lck_hold", olck[2], 1);
    @(negedge clk);
    chk("t2_lck_clr", olck[2], 0);
    chk("t2_tail_vch", ovch, 2);
    drain("t2_drain");
    ack(4'b0100);
    ack(4'b0100);

    // Round robin: exhaust all credits, preload 2 per VC, then return credits
    for (int v = 0; v < 4; v++)
      for (int k = 0; k < 4; k++)
        put(v, 2'b00, 1'b1);
    drain("t3_pre_drain");
    for (int k = 0; k < 2; k++)
      for (int v = 0; v < 4; v++)
        put(v, 2'b00, 1'b1);
    idle(2);
    chk("t3_ordy", ordy, 4'hf);
    base = n_sent;
    idle(3);
    chk("t3_stalled", n_sent - base, 0);
    log_vc.delete();
    log_cyc.delete();
    ack(4'hf);
    ack(4'hf);
    drain("t3_drain");
    chk("t3_nsent", log_vc.size(), 8);
    if (log_vc.size() == 8) begin
      for (int i = 0; i < 8; i++) chk("t3_order", log_vc[i], i % 4);
      chk("t3_b2b", log_cyc[7] - log_cyc[0], 7);
    end

    // Credit limit on VC1
    repeat (4) ack(4'b0010);
    base = n_sent;
    for (int k = 0; k < 6; k++) begin
      put(1, 2'b00, k < 4);
      if (k == 4) d5 = last_d;
      if (k == 5) d6 = last_d;
    end
    drain("t4_drain");
    chk("t4_sent4", n_sent - base, 4);
    chk("t4_ordy1", ordy[1], 1);
    sb_push(1, d5);
    ack(4'b0010);
    drain("t4_drain5");
    chk("t4_sent5", n_sent - base, 5);
    sb_push(1, d6);
    ack(4'b0010);
    drain("t4_drain6");

    // Credit saturation and send+iack on VC0
    repeat (6) ack(4'b0001);
    chk("t6_no_err", err_ovf, 0);
    base = n_sent;
    for (int k = 0; k < 5; k++) begin
      put(0, 2'b00, k < 4);
      if (k == 4) d5 = last_d;
    end
    drain("t6_drain");
    chk("t6_sat_sent", n_sent - base, 4);
    sb_push(0, d5);
    put(0, 2'b00, 1'b1);
    put(0, 2'b00, 1'b0);
    ack(4'b0001);
    ack(4'b0001);
    drain("t6_drain2");
    chk("t6_sendack", n_sent - base, 6);
    chk("t6_ordy0", ordy[0], 1);

    // Full VC3, overflow drop, write+pop on a full FIFO
    base = n_sent;
    for (int k = 0; k < 4; k++) put(3, 2'b00, 1'b1);
    chk("t5_full", ordy[3], 0);
    chk("t5_err0", err_ovf, 0);
    put(3, 2'b00, 1'b0);
    chk("t5_err1", err_ovf, 1);
    chk("t5_still_full", ordy[3], 0);
    iack = 4'b1000;
    @(negedge clk);
    iack = '0;
    put(3, 2'b00, 1'b1);
    chk("t5_wp_full", ordy[3], 0);
    idle(1);
    chk("t5_wp_sent", n_sent - base, 1);
    repeat (4) ack(4'b1000);
    drain("t5_drain");
    chk("t5_sent_all", n_sent - base, 5);
    chk("t5_ordy3", ordy[3], 1);
    chk("t5_sticky", err_ovf, 1);

    // Async reset mid-packet
    put(3, 2'b01, 1'b0);
    ack(4'b0010);
    put(1, 2'b01, 1'b1);
    @(negedge clk);
    chk("t1_pre_valid", ovalid, 1);
    chk("t1_pre_lck", olck, 4'b1010);
    #2 reset = 1'b1;
    #1;
    chk("t1_ovalid", ovalid, 0);
    chk("t1_olck", olck, 4'h0);
    chk("t1_ordy", ordy, 4'hf);
    chk("t1_err", err_ovf, 0);
    sb_clear();
    idle(2);
    reset = 1'b0;
    base = n_sent;
    for (int k = 0; k < 5; k++) put(3, 2'b00, k < 4);
    drain("t1_drain");
    chk("t1_credits", n_sent - base, 4);
    chk("t1_olck_after", olck, 4'h0);
    chk("t1_idle", ovalid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
